// File: rtl/div_ctrl.sv
// Requester-side controller for the iterative unsigned divider: turns RV32M DIV/DIVU/REM/REMU
// into magnitude divides, resolves divide-by-zero and signed overflow locally, and sign-corrects.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    output logic            div_req_o,
    output logic            div_is_q_o,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            div_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};

    // Conditional two's complement negation, modulo 2^XLEN (|MIN_NEG| stays MIN_NEG).
    function automatic logic [XLEN-1:0] neg_cond(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + ONE) : v;
    endfunction

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic            req_q, req_d;
    logic            is_q_q, is_q_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] temp_q, temp_d;

    logic            op_signed;
    logic            op_is_q;
    logic            op_sa;
    logic            op_sb;

    always_comb begin
        op_signed = ~op_i[0];
        op_is_q   = ~op_i[1];
        op_sa     = op_signed & rs1_i[XLEN-1];
        op_sb     = op_signed & rs2_i[XLEN-1];

        state_d = state_q;
        done_d  = 1'b0;
        req_d   = req_q;
        is_q_d  = is_q_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        temp_d  = temp_q;

        unique case (state_q)
            S_IDLE: begin
                // A flush arriving with the issue pulse cancels that issue.
                if (start_i && !flush_i) begin
                    is_q_d = op_is_q;
                    sa_d   = op_sa;
                    sb_d   = op_sb;
                    if (rs2_i == '0) begin
                        res_d   = op_is_q ? ALL_ONES : rs1_i;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (op_signed && rs1_i == MIN_NEG && rs2_i == ALL_ONES) begin
                        res_d   = op_is_q ? MIN_NEG : '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        a_d     = neg_cond(op_sa, rs1_i);
                        b_d     = neg_cond(op_sb, rs2_i);
                        req_d   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (div_ready_i) begin
                    temp_d  = div_result_i;
                    req_d   = 1'b0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = neg_cond(is_q_q ? (sa_q ^ sb_q) : sa_q, temp_q);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            is_q_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            req_q   <= req_d;
            is_q_q  <= is_q_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            temp_q  <= temp_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign result_o   = res_q;
    assign div_a_o    = a_q;
    assign div_b_o    = b_q;
    assign div_req_o  = req_q;
    assign div_is_q_o = is_q_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural unsigned divider of programmable latency.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic        busy_o, done_o, div_req_o, div_is_q_o, div_ready_i;
    logic [31:0] result_o, div_a_o, div_b_o, div_result_i;

    int n_chk = 0;
    int n_err = 0;
    int lat   = 3;
    int cnt   = 0;
    logic [31:0] exp_last = '0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_req_o(div_req_o),
        .div_is_q_o(div_is_q_o), .div_result_i(div_result_i),
        .div_ready_i(div_ready_i)
    );

    // Divider model: aborts whenever req is low, pulses ready after lat request cycles.
    always @(posedge clk) begin
        if (rst_i || !div_req_o) begin
            cnt         <= 0;
            div_ready_i <= 1'b0;
        end else if (div_ready_i) begin
            cnt         <= 0;
            div_ready_i <= 1'b0;
        end else if (cnt >= lat - 1) begin
            div_ready_i  <= 1'b1;
            div_result_i <= (div_b_o == 0) ? 32'h0 :
                            (div_is_q_o ? div_a_o / div_b_o : div_a_o % div_b_o);
        end else begin
            cnt <= cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; issues one op and follows it to completion.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit special, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [31:0] exp);
        int cyc;
        bit bad;
        bit rdy;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1; bad = 1'b0; rdy = 1'b0;
        if (special && div_req_o) bad = 1'b1;
        if (!special) begin
            check({tag, " div_a"}, div_a_o, ea);
            check({tag, " div_b"}, div_b_o, eb);
            check({tag, " is_q"}, {31'b0, div_is_q_o}, {31'b0, ~op[1]});
        end
        while (!done_o && cyc < 300) begin
            if (special && div_req_o) bad = 1'b1;
            if (!special && !rdy && !div_req_o) bad = 1'b1;
            if (div_ready_i) rdy = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done"}, {31'b0, done_o}, 32'd1);
        check({tag, " result"}, result_o, exp);
        check({tag, " req_protocol"}, {31'b0, bad}, 32'd0);
        if (special) check({tag, " latency"}, cyc, 32'd1);
        exp_last = exp;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        bit saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done_o) saw = 1'b1;
            @(negedge clk);
        end
        check({tag, " no_done"}, {31'b0, saw}, 32'd0);
    endtask

    initial begin
        int cyc;
        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; rs1_i = '0; rs2_i = '0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst done", {31'b0, done_o}, 32'd0);
        check("rst req", {31'b0, div_req_o}, 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst div_a", div_a_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Signed and unsigned through the divider
        run_op("div -7/2",   DIV,  32'hFFFFFFF9, 32'd2,        0, 32'd7, 32'd2, 32'hFFFFFFFD);
        run_op("rem -7%2",   REM,  32'hFFFFFFF9, 32'd2,        0, 32'd7, 32'd2, 32'hFFFFFFFF);
        run_op("rem 7%-2",   REM,  32'd7,        32'hFFFFFFFE, 0, 32'd7, 32'd2, 32'd1);
        lat = 6;
        run_op("divu 100/7", DIVU, 32'd100,      32'd7,        0, 32'd100, 32'd7, 32'd14);
        run_op("remu 100%7", REMU, 32'd100,      32'd7,        0, 32'd100, 32'd7, 32'd2);
        run_op("divu max/1", DIVU, 32'hFFFFFFFF, 32'd1,        0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);

        // Divide by zero and signed overflow resolved locally
        run_op("div 5/0",    DIV,  32'd5,        32'd0,        1, 32'd0, 32'd0, 32'hFFFFFFFF);
        run_op("rem 5%0",    REM,  32'd5,        32'd0,        1, 32'd0, 32'd0, 32'd5);
        run_op("remu dead%0", REMU, 32'hDEADBEEF, 32'd0,       1, 32'd0, 32'd0, 32'hDEADBEEF);
        run_op("rem -7%0",   REM,  32'hFFFFFFF9, 32'd0,        1, 32'd0, 32'd0, 32'hFFFFFFF9);
        run_op("divu 9/0",   DIVU, 32'd9,        32'd0,        1, 32'd0, 32'd0, 32'hFFFFFFFF);
        run_op("div ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 32'h80000000);
        run_op("rem ovf",    REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'd0, 32'd0);
        run_op("divu min/max", DIVU, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_op("div min/2",  DIV,  32'h80000000, 32'd2,        0, 32'h80000000, 32'd2, 32'hC0000000);

        // Flush while waiting on the divider
        lat = 40;
        start_i = 1'b1; op_i = DIV; rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_wait req", {31'b0, div_req_o}, 32'd0);
        check("flush_wait busy", {31'b0, busy_o}, 32'd0);
        check("flush_wait result", result_o, exp_last);
        no_done("flush_wait", 50);

        // Flush coinciding with div_ready_i
        lat = 5;
        start_i = 1'b1; op_i = DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (!div_ready_i && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("flush_rdy ready_seen", {31'b0, div_ready_i}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_rdy busy", {31'b0, busy_o}, 32'd0);
        check("flush_rdy result", result_o, exp_last);
        no_done("flush_rdy", 10);
        run_op("after flush", REMU, 32'd100, 32'd7, 0, 32'd100, 32'd7, 32'd2);

        // Flush together with start in idle cancels the issue
        flush_i = 1'b1; start_i = 1'b1; op_i = DIVU; rs1_i = 32'd50; rs2_i = 32'd5;
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        check("flush_start busy", {31'b0, busy_o}, 32'd0);
        check("flush_start req", {31'b0, div_req_o}, 32'd0);
        no_done("flush_start", 3);

        // Reset in the middle of a wait
        lat = 40;
        start_i = 1'b1; op_i = DIV; rs1_i = 32'hFFFFFFF9; rs2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("mid_rst busy", {31'b0, busy_o}, 32'd0);
        check("mid_rst req", {31'b0, div_req_o}, 32'd0);
        check("mid_rst is_q", {31'b0, div_is_q_o}, 32'd0);
        check("mid_rst div_a", div_a_o, 32'd0);
        check("mid_rst div_b", div_b_o, 32'd0);
        check("mid_rst result", result_o, 32'd0);
        exp_last = '0;
        no_done("mid_rst", 5);

        // Starts while busy are ignored
        lat = 15;
        start_i = 1'b1; op_i = DIV; rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1; op_i = DIVU; rs1_i = 32'd50; rs2_i = 32'd5;
            @(negedge clk);
            start_i = 1'b0;
            @(negedge clk);
        end
        check("busy_start div_a", div_a_o, 32'd100);
        check("busy_start div_b", div_b_o, 32'd7);
        cyc = 0;
        while (!done_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_start done", {31'b0, done_o}, 32'd1);
        check("busy_start result", result_o, 32'd14);
        @(negedge clk);
        no_done("busy_start", 20);

        // Back-to-back issues
        lat = 2;
        run_op("b2b 1", DIV,  32'hFFFFFFF9, 32'd2, 0, 32'd7, 32'd2, 32'hFFFFFFFD);
        run_op("b2b 2", REMU, 32'hDEADBEEF, 32'd0, 1, 32'd0, 32'd0, 32'hDEADBEEF);
        run_op("b2b 3", DIV,  32'h80000000, 32'd2, 0, 32'h80000000, 32'd2, 32'hC0000000);
        run_op("b2b 4", REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 0, 32'd100, 32'd7, 32'hFFFFFFFE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Requester-side controller for the iterative unsigned divider device; sits between the execute stage and that divider.
- Accepts RV32M DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes.
- Drives the divider's level-held req/is_q handshake, then sign-corrects the returned value.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally without issuing a divider request.

Parameters:
XLEN, 32, operand/result width (only 32 supported; special-case constants assume it)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  issue pulse from execute stage; sampled only in S_IDLE
op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled with start_i
rs1_i  input  XLEN  dividend; sampled with start_i
rs2_i  input  XLEN  divisor; sampled with start_i
flush_i  input  1  pipeline flush; aborts any in-flight operation
busy_o  output  1  high whenever state != S_IDLE (stall request)
done_o  output  1  one-cycle completion pulse
result_o  output  XLEN  final RV32M result; valid with done_o, held until next completion
div_a_o  output  XLEN  dividend magnitude to divider
div_b_o  output  XLEN  divisor magnitude to divider
div_req_o  output  1  divider request, held high until div_ready_i
div_is_q_o  output  1  1=quotient, 0=remainder
div_result_i  input  XLEN  divider result
div_ready_i  input  1  divider completion pulse

Behaviour:
- Reset (rst_i=1 at an edge): state<=S_IDLE; busy_o, done_o, div_req_o, div_is_q_o <= 0; result_o, div_a_o, div_b_o <= 0. Reset overrides every other input, mid-operation included.
- States: S_IDLE, S_WAIT, S_FIX, S_DONE. All outputs are registered; busy_o is decoded from state.
- S_IDLE with start_i=1:
  - signed = (op_i[0]==0); is_q = (op_i[1]==0).
  - sa = signed & rs1_i[31]; sb = signed & rs2_i[31].
  - Latch is_q, sa, sb and the op.
- Special cases, decided in S_IDLE, go directly to S_DONE with result_o loaded and div_req_o never raised:
  - rs2_i==0: quotient = all ones (DIV and DIVU); remainder = rs1_i (REM and REMU).
  - DIV/REM with rs1_i==0x80000000 and rs2_i==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Normal case:
  - div_a_o <= sa ? -rs1_i : rs1_i; div_b_o <= sb ? -rs2_i : rs2_i.
  - Two's complement negation. |0x80000000| = 0x80000000 as unsigned.
  - div_is_q_o <= is_q; div_req_o <= 1; state <= S_WAIT.
- S_WAIT:
  - Hold div_req_o, div_a_o, div_b_o and div_is_q_o stable; the divider aborts if req drops.
  - On div_ready_i=1: capture div_result_i into a temp register; div_req_o <= 0; state <= S_FIX.
  - The controller is latency-insensitive and waits indefinitely.
  - The divider may briefly restart while req is still high; the low req in the following cycle aborts it, and that result is never consumed.
- S_FIX:
  - Quotient: result_o <= (sa^sb) ? -temp : temp.
  - Remainder: result_o <= sa ? -temp : temp.
  - state <= S_DONE.
- S_DONE: done_o=1 for exactly this cycle; state <= S_IDLE. A new start_i is accepted at the next S_IDLE cycle, so div_req_o is low for at least 2 cycles between requests.
- Latency (start edge to done_o): special case = 1 cycle; normal = divider latency + 3 cycles.
- start_i while busy_o=1: ignored, no queuing.
- flush_i=1 at an edge in any non-IDLE state: state <= S_IDLE, div_req_o <= 0, done_o <= 0, result_o unchanged.
  - Flush beats a simultaneous div_ready_i; that result is discarded.
  - flush_i together with start_i in S_IDLE: start is ignored.
- Signed wrap: all negation is modulo 2^32; no saturation.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> div_a_o=7, div_b_o=2, div_is_q_o=1; done_o pulse with result_o=0xFFFFFFFD (-3). REM same operands -> result_o=0xFFFFFFFF (-1). REM 7,-2 -> 1.
- DIVU 100,7 -> result_o=14; REMU 100,7 -> 2; DIVU 0xFFFFFFFF,1 -> 0xFFFFFFFF; div_req_o held high continuously until div_ready_i.
- DIV 5,0 -> 0xFFFFFFFF; REM 5,0 -> 5; REMU 0xDEADBEEF,0 -> 0xDEADBEEF. div_req_o stays 0 and done_o arrives 1 cycle after start.
- Overflow: DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same -> 0; no divider request. DIV 0x80000000,2 -> 0xC0000000 through the divider.
- Flush in S_WAIT 10 cycles after start -> div_req_o low next cycle, no done_o, result_o unchanged. Flush in the same cycle as div_ready_i -> no done_o. Next start -> correct result.
- rst_i mid-S_WAIT -> all outputs 0 next cycle. start_i pulses while busy_o=1 are ignored. Back-to-back issues complete in order with correct results.
